// File: rtl/ring_meas_pkg.sv
// Shared FSM state type, counter-width and saturating-increment helpers for the
// ring oscillator frequency meter.
package ring_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meas_state_e;

    localparam int GATE_CYCLES_DEFAULT   = 1024;
    localparam int SETTLE_CYCLES_DEFAULT = 16;
    localparam int CNT_W_DEFAULT         = 16;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level, synchronously reset to 0.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/ring_freq_meter.sv
// Ring oscillator frequency meter: releases the ring, counts synchronised ack rising edges over a
// fixed clk gate window and hands the count out on a valid/ready port. Option: RING_FREQ_MINMAX_EN.
module ring_freq_meter
    import ring_meas_pkg::*;
#(
    parameter int GATE_CYCLES   = GATE_CYCLES_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             ring_ack,
    output logic             ring_rst,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             dead
`ifdef RING_FREQ_MINMAX_EN
    ,
    output logic [CNT_W-1:0] cnt_min,
    output logic [CNT_W-1:0] cnt_max
`endif
);

    localparam int GATE_W   = ctr_width(GATE_CYCLES);
    localparam int SETTLE_W = ctr_width(SETTLE_CYCLES);
    localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [31:0]         CNT_MAX     = 32'({CNT_W{1'b1}});

    meas_state_e         state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]    result_q, result_d;
    logic                valid_q, valid_d;
    logic                dead_q, dead_d;
    logic                ring_rst_q, ring_rst_d;
    logic                busy_q, busy_d;

    logic                ack_sync;
    logic                ack_prev_q;
    logic                rise;
    logic [CNT_W-1:0]    edge_inc;
    logic                window_end;

    bit_sync u_ack_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ring_ack),
        .sync_o  (ack_sync)
    );

    assign rise       = ack_sync & ~ack_prev_q;
    assign edge_inc   = rise ? CNT_W'(sat_inc(32'(edge_cnt_q), CNT_MAX)) : edge_cnt_q;
    assign window_end = (state_q == MEASURE) && (gate_cnt_q == GATE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            dead_q       <= 1'b0;
            ring_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            ack_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            dead_q       <= dead_d;
            ring_rst_q   <= ring_rst_d;
            busy_q       <= busy_d;
            ack_prev_q   <= ack_sync;
        end
    end

    // Edges seen while settling are discarded; the count restarts as the gate opens.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        result_d     = result_q;
        valid_d      = valid_q;
        dead_d       = dead_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d    = MEASURE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            MEASURE: begin
                edge_cnt_d = edge_inc;
                if (gate_cnt_q == GATE_LAST) begin
                    state_d  = DONE;
                    result_d = edge_inc;
                    dead_d   = (edge_inc == '0);
                    valid_d  = 1'b1;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                end
            end
            DONE: begin
                if (valid_q && result_ready) begin
                    valid_d      = 1'b0;
                    settle_cnt_d = '0;
                    state_d      = continuous ? SETTLE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ring_rst_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign ring_rst     = ring_rst_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign dead         = dead_q;

`ifdef RING_FREQ_MINMAX_EN
    logic [CNT_W-1:0] cnt_min_q;
    logic [CNT_W-1:0] cnt_max_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_min_q <= '1;
            cnt_max_q <= '0;
        end else if (window_end) begin
            if (edge_inc < cnt_min_q) cnt_min_q <= edge_inc;
            if (edge_inc > cnt_max_q) cnt_max_q <= edge_inc;
        end
    end

    assign cnt_min = cnt_min_q;
    assign cnt_max = cnt_max_q;
`else
    logic unused_window_end;
    assign unused_window_end = window_end;
`endif

endmodule
